sysram_arbiter: RTL
===================

Name: sysram_arbiter

Overview:
- Time-multiplexes the single-port 2 KB system RAM between three requesters: the VGA renderer's screen fetch, the 6502 core, and an auxiliary port used by the loader/IO-register logic.
- Replaces the ad-hoc cpu_ready logic at top level and owns the RAM address, write-data and write-enable mux.
- Stalls the CPU through RDY only at instruction boundaries (SYNC). Priority is VGA > AUX > CPU, with a guaranteed minimum CPU slice.

Parameters:
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- CPU_MIN_SLICE, 4, minimum cycles the CPU owns RAM after regaining it before AUX may preempt; VGA is exempt.

Ports:
- clk  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  screen_read_en from the renderer; level request.
- vga_addr  in  ADDR_WIDTH  screen fetch address.
- vga_valid  out  1  vga_rdata holds the word for the vga_addr presented one cycle earlier.
- vga_rdata  out  DATA_WIDTH  fetched screen data.
- cpu_addr  in  ADDR_WIDTH  CPU address bus, low bits.
- cpu_wdata  in  DATA_WIDTH  CPU data out.
- cpu_we  in  1  CPU write enable.
- cpu_sync  in  1  CPU is fetching an opcode.
- cpu_rdy  out  1  CPU RDY.
- cpu_rdata  out  DATA_WIDTH  CPU data in; always equals ram_rdata.
- aux_req  in  1  auxiliary access request; held until granted.
- aux_we  in  1  auxiliary write, 0 = read.
- aux_addr  in  ADDR_WIDTH  auxiliary address.
- aux_wdata  in  DATA_WIDTH  auxiliary write data.
- aux_gnt  out  1  auxiliary access performed this cycle.
- aux_rvalid  out  1  aux_rdata is valid; asserted the cycle after a read grant.
- aux_rdata  out  DATA_WIDTH  auxiliary read data.
- ram_addr  out  ADDR_WIDTH  RAM address (read and write).
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_WIDTH  RAM read data; synchronous, valid 1 cycle after the address.

Behaviour:
- States: RST, CPU, DRAIN, VGA, AUX. State is registered; the RAM mux decodes the current state combinationally.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = RST.
  - cpu_rdy = 0, aux_gnt = 0, aux_rvalid = 0, vga_valid = 0, ram_we = 0.
  - Slice counter = 0.
- RST: on the first clk edge with reset low, go to CPU, or to VGA if vga_req is high.
- CPU:
  - cpu_rdy = 1; ram_addr = cpu_addr; ram_wdata = cpu_wdata; ram_we = cpu_we.
  - Slice counter increments, saturating at CPU_MIN_SLICE.
  - If cpu_sync & vga_req, go to VGA.
  - Else if cpu_sync & aux_req & (counter == CPU_MIN_SLICE), go to AUX.
  - Else if (vga_req | eligible aux_req) & !cpu_sync, go to DRAIN.
- DRAIN:
  - Same outputs as CPU; the CPU runs until its next opcode fetch.
  - On cpu_sync, go to VGA if vga_req, else AUX if aux_req, else stay in CPU.
  - If the requests drop before sync, return to CPU.
- Stall timing: the cpu_rdy fall is combinational on leaving CPU/DRAIN. The sync-cycle opcode read completes (registered RDY deasserted next cycle), which matches the current top-level behaviour.
- VGA:
  - cpu_rdy = 0; ram_addr = vga_addr; ram_we = 0.
  - vga_valid = registered copy of (state==VGA), so data trails the address by 1 cycle.
  - On !vga_req, go to AUX if aux_req, else CPU.
- AUX:
  - Exactly one cycle: cpu_rdy = 0; ram_addr = aux_addr; ram_we = aux_we; ram_wdata = aux_wdata; aux_gnt = 1.
  - Next state is VGA if vga_req, else CPU. The slice counter resets to 0 on entry to CPU.
  - aux_rvalid = registered (aux_gnt & !aux_we); aux_rdata = ram_rdata during that cycle.
- Write protection: ram_we is never asserted while cpu_rdy = 0, except for the AUX write.
- vga_rdata and cpu_rdata wire straight from ram_rdata.
- Simultaneous vga_req and aux_req at sync: VGA wins. AUX is served immediately after the VGA window, before the CPU resumes.
- vga_req rising while in AUX: AUX completes its single cycle, then the arbiter enters VGA directly.
- Starvation bound:
  - AUX waits at most one CPU instruction plus one VGA window.
  - The CPU is guaranteed CPU_MIN_SLICE cycles between consecutive AUX grants when VGA is idle.

Test Plan:
- Reset released with no requests → cpu_rdy rises 1 cycle after reset low; ram_addr follows cpu_addr = 0x123; ram_we mirrors cpu_we.
- vga_req raised mid-instruction, cpu_sync 3 cycles later → state DRAIN for 3 cycles, then cpu_rdy = 0. ram_addr = vga_addr 0x200..0x20F over 16 cycles; vga_valid high for 16 cycles, each lagging its address by 1. The CPU resumes the cycle after vga_req falls.
- aux write 0xA5 to 0x0FE with VGA idle → aux_gnt pulses 1 cycle at the next cpu_sync; ram_we = 1 with addr 0x0FE and data 0xA5; the CPU stalls exactly 1 cycle. A subsequent aux read of 0x0FE gives aux_rvalid the next cycle with aux_rdata = 0xA5.
- Continuous aux_req, VGA idle → grants separated by ≥ CPU_MIN_SLICE (4) CPU cycles; the CPU is never starved.
- vga_req and aux_req both high at cpu_sync → VGA window first, then a 1-cycle AUX grant, then CPU; no ram_we during VGA even if cpu_we = 1.
- reset asserted during a VGA window and during an AUX write → all outputs drop asynchronously the same cycle (cpu_rdy = 0, ram_we = 0, aux_gnt = 0); after release the state goes RST→CPU and no spurious aux_rvalid appears.

Source files
------------

// File: rtl/sysram_arbiter.sv
`timescale 1ns/1ps
// Time-multiplexes the single-port system RAM between VGA screen fetch, the 6502 core and an
// auxiliary loader/IO port. Priority VGA > AUX > CPU; the CPU is only stalled at SYNC.
module sysram_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CPU_MIN_SLICE = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_valid,
    output logic [DATA_WIDTH-1:0] vga_rdata,

    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_sync,
    output logic                  cpu_rdy,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_wdata,
    output logic                  aux_gnt,
    output logic                  aux_rvalid,
    output logic [DATA_WIDTH-1:0] aux_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int unsigned SliceW = $clog2(CPU_MIN_SLICE + 1);

    typedef enum logic [2:0] {
        StRst,
        StCpu,
        StDrain,
        StVga,
        StAux
    } state_e;

    state_e            state_q;
    logic [SliceW-1:0] slice_cnt_q;
    logic              slice_full;
    logic              aux_eligible;
    logic              cpu_owns;

    assign slice_full   = (slice_cnt_q == SliceW'(CPU_MIN_SLICE));
    assign aux_eligible = aux_req & slice_full;
    assign cpu_owns     = (state_q == StCpu) || (state_q == StDrain);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRst;
            slice_cnt_q <= '0;
            vga_valid   <= 1'b0;
            aux_rvalid  <= 1'b0;
        end else begin
            vga_valid  <= (state_q == StVga);
            aux_rvalid <= (state_q == StAux) & ~aux_we;

            // The slice restarts whenever the CPU loses the RAM, so it is zero on every re-entry.
            if (cpu_owns) begin
                if (!slice_full) begin
                    slice_cnt_q <= slice_cnt_q + SliceW'(1);
                end
            end else begin
                slice_cnt_q <= '0;
            end

            case (state_q)
                StRst: state_q <= vga_req ? StVga : StCpu;
                StCpu: begin
                    if (cpu_sync && vga_req) begin
                        state_q <= StVga;
                    end else if (cpu_sync && aux_eligible) begin
                        state_q <= StAux;
                    end else if (!cpu_sync && (vga_req || aux_eligible)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (cpu_sync) begin
                        if (vga_req) begin
                            state_q <= StVga;
                        end else if (aux_req) begin
                            state_q <= StAux;
                        end else begin
                            state_q <= StCpu;
                        end
                    end else if (!vga_req && !aux_req) begin
                        state_q <= StCpu;
                    end
                end
                StVga: begin
                    if (!vga_req) begin
                        state_q <= aux_req ? StAux : StCpu;
                    end
                end
                StAux:   state_q <= vga_req ? StVga : StCpu;
                default: state_q <= StRst;
            endcase
        end
    end

    // RAM mux decoded from the registered state so RDY drops in the same cycle the CPU loses RAM.
    always_comb begin
        cpu_rdy   = 1'b0;
        aux_gnt   = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        case (state_q)
            StCpu, StDrain: begin
                cpu_rdy = 1'b1;
                ram_we  = cpu_we;
            end
            StVga: begin
                ram_addr = vga_addr;
            end
            StAux: begin
                ram_addr  = aux_addr;
                ram_wdata = aux_wdata;
                ram_we    = aux_we;
                aux_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign vga_rdata = ram_rdata;
    assign cpu_rdata = ram_rdata;
    assign aux_rdata = ram_rdata;

endmodule
